// File: rtl/a0_trace_buffer.sv
// a0 change tracer: captures {a0, cycle stamp} on every a0 change into a FIFO drained over valid/ready.
// Define A0_TRACE_STAMP_EN to include the stamp counter and stamp storage; otherwise out_stamp is 0.
module a0_trace_buffer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         a0,
    input  logic                     en,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [STAMP_W-1:0]       out_stamp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             armed;
    logic [WIDTH-1:0] prev_a0;
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic capture;
    logic pop;
    logic full;
    logic push;
    logic drop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign out_valid = (cnt != '0);
    assign pop     = out_valid && out_ready;
    assign capture = en && (armed || (a0 != prev_a0));
    // A pop frees the slot at the same edge, so a full FIFO still accepts the capture.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    assign count    = cnt;
    assign overflow = ovf;
    assign out_data = out_valid ? data_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            armed   <= 1'b1;
            prev_a0 <= '0;
        end else begin
            prev_a0 <= a0;
            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
                ovf    <= 1'b0;
                armed  <= 1'b1;
            end else begin
                if (en)
                    armed <= 1'b0;
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)
                    cnt <= cnt + CNT_W'(1);
                else if (pop && !push)
                    cnt <= cnt - CNT_W'(1);
                if (drop)
                    ovf <= 1'b1;
            end
        end
    end

    // Storage carries no reset; out_valid gates what is visible.
    always_ff @(posedge clk) begin
        if (push && !clear)
            data_mem[wr_ptr] <= a0;
    end

`ifdef A0_TRACE_STAMP_EN
    logic [STAMP_W-1:0] stamp;
    logic [STAMP_W-1:0] stamp_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stamp <= '0;
        else
            stamp <= stamp + STAMP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            stamp_mem[wr_ptr] <= stamp;
    end

    assign out_stamp = out_valid ? stamp_mem[rd_ptr] : '0;
`else
    assign out_stamp = '0;
`endif

endmodule
